// File: rtl/result_writeback_if.sv
// rtl/result_writeback_if.sv - Avalon-MM write bus between result_writeback and the memory wrapper
interface result_writeback_if;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [63:0] avm_writedata;
  logic [7:0]  avm_byteenable;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest
  );
endinterface

// File: rtl/result_writeback.sv
// rtl/result_writeback.sv - snapshots N lane results and writes them two per 64-bit word over Avalon-MM
// Optional trailer word carrying the lane sum is enabled by defining RESULT_WB_CHECKSUM_EN.
module result_writeback #(
  parameter int unsigned N         = 8,
  parameter int unsigned RES_WIDTH = 24,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0010
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [RES_WIDTH-1:0] c_in [N],
  result_writeback_if.master   avm,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state,
  output logic [2:0]           dbg_word
);
`ifdef RESULT_WB_CHECKSUM_EN
  localparam int unsigned NW = N / 2 + 1;
`else
  localparam int unsigned NW = N / 2;
`endif
  localparam int unsigned IW = ($clog2(NW) < 3) ? 3 : $clog2(NW);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e               state_q;
  logic [RES_WIDTH-1:0] snap_q [N];
  logic [IW-1:0]        word_q, word_d;
  logic [31:0]          addr_q, addr_d;
  logic [63:0]          data_q, data_d;
  logic                 write_q, busy_q, done_q;
  logic                 accept, last_word;

  assign accept    = write_q && !avm.avm_waitrequest;
  assign last_word = (word_q == IW'(NW - 1));
  // CAPTURE presents word 0; every acceptance presents the following word
  assign word_d    = (state_q == CAPTURE) ? '0 : word_q + IW'(1);
  assign addr_d    = BASE_ADDR + 32'(word_d);

`ifdef RESULT_WB_CHECKSUM_EN
  logic [31:0] sum;
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + 32'(snap_q[i]);
  end
`endif

  always_comb begin
    data_d = '0;
`ifdef RESULT_WB_CHECKSUM_EN
    if (word_d == IW'(N / 2)) data_d = {32'hA5A5_A5A5, sum};
`endif
    for (int k = 0; k < N / 2; k++) begin
      if (word_d == IW'(k)) data_d = {32'(snap_q[2*k+1]), 32'(snap_q[2*k])};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N; i++) snap_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) snap_q[i] <= c_in[i];
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          word_q  <= word_d;
          addr_q  <= addr_d;
          data_q  <= data_d;
          write_q <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          if (accept) begin
            if (last_word) begin
              state_q <= DONE;
              write_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              word_q  <= '0;
              addr_q  <= '0;
              data_q  <= '0;
            end else begin
              word_q <= word_d;
              addr_q <= addr_d;
              data_q <= data_d;
            end
          end
        end
        DONE: begin
          // level-held start keeps us parked here so the top FSM sees no second burst
          if (!start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm.avm_address    = addr_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_writedata  = data_q;
  assign avm.avm_byteenable = {8{write_q}};
  assign busy               = busy_q;
  assign done               = done_q;
  assign dbg_state          = state_q;
  assign dbg_word           = word_q[2:0];
endmodule

// File: tb/tb_result_writeback.sv
// tb/tb_result_writeback.sv - table, directed and randomized checks of result_writeback against a word-list model
module tb_result_writeback;
  localparam int N  = 8;
  localparam int RW = 24;
`ifdef RESULT_WB_CHECKSUM_EN
  localparam int NW = N / 2 + 1;
  localparam logic [63:0] BASIC_LAST = 64'hA5A5A5A5_00002400;
  localparam logic [63:0] ONES_LAST  = 64'hA5A5A5A5_07FFFFF8;
`else
  localparam int NW = N / 2;
  localparam logic [63:0] BASIC_LAST = 64'h00000800_00000700;
  localparam logic [63:0] ONES_LAST  = 64'h00FFFFFF_00FFFFFF;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] c_in [N];
  logic          busy, done;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_word;
  int            tests = 0;
  int            fails = 0;

  result_writeback_if avm();

  result_writeback #(.N(N), .RES_WIDTH(RW), .BASE_ADDR(32'h0000_0010)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .c_in      (c_in),
    .avm       (avm),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .dbg_word  (dbg_word)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*RW-1:0] vals;
    int              pct;
    int              mutate;
    int              stall_word;
    int              stall_len;
    int              hold;
    int              exp_done;
    int              has_exp;
    logic [63:0]     exp_w0;
    logic [63:0]     exp_wlast;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // The written image: lane pairs in order, then the optional sum trailer
  function automatic logic [63:0] model_word(input logic [N*RW-1:0] v, input int k);
    logic [31:0] s;
    if (k < N / 2) return {32'(v[(2*k+1)*RW +: RW]), 32'(v[2*k*RW +: RW])};
    s = 0;
    for (int i = 0; i < N; i++) s = s + 32'(v[i*RW +: RW]);
    return {32'hA5A5A5A5, s};
  endfunction

  task automatic run_burst(input vec_t t);
    logic [31:0] got_a[$];
    logic [63:0] got_d[$];
    logic [31:0] pa;
    logic [63:0] pd;
    logic        prev_stall;
    int          cur, waits, done_cyc, stalls;
    for (int i = 0; i < N; i++) c_in[i] = t.vals[i*RW +: RW];
    start = 1'b1;
    @(posedge clk);
    cur = 0; waits = 0; done_cyc = -1; stalls = 0; prev_stall = 1'b0;
    pa = '0; pd = '0;
    for (int n = 0; n < 300 && done_cyc < 0; n++) begin
      #1;
      cur++;
      if (t.mutate != 0 && cur == 1) for (int i = 0; i < N; i++) c_in[i] = '1;
      if (done) begin
        done_cyc = cur;
      end else begin
        chk("busy", busy, 1);
        chk("dbg_state", dbg_state, (cur == 1) ? 1 : 2);
        chk("byteenable", avm.avm_byteenable, avm.avm_write ? 8'hFF : 8'h00);
        if (avm.avm_write) chk("dbg_word", dbg_word, got_a.size());
        if (prev_stall) begin
          chk("hold_write", avm.avm_write, 1);
          chk("hold_addr", avm.avm_address, pa);
          chk("hold_data", avm.avm_writedata, pd);
        end
        if (avm.avm_write && t.stall_len > 0 && avm.avm_address == 32'h10 + t.stall_word
            && stalls < t.stall_len) begin
          avm.avm_waitrequest = 1'b1;
          stalls++;
        end else if (avm.avm_write) begin
          avm.avm_waitrequest = ($urandom_range(99) < t.pct);
        end else begin
          avm.avm_waitrequest = 1'($urandom_range(1));
        end
        if (avm.avm_write && avm.avm_waitrequest) waits++;
        if (avm.avm_write && !avm.avm_waitrequest) begin
          got_a.push_back(avm.avm_address);
          got_d.push_back(avm.avm_writedata);
        end
        prev_stall = avm.avm_write && avm.avm_waitrequest;
        pa = avm.avm_address;
        pd = avm.avm_writedata;
        @(posedge clk);
      end
    end
    chk("done_cycle", done_cyc, NW + 2 + waits);
    if (t.exp_done >= 0) chk("done_cycle_ref", done_cyc, t.exp_done);
    chk("write_count", got_a.size(), NW);
    for (int k = 0; k < NW; k++) begin
      if (k < got_a.size()) begin
        chk("word_addr", got_a[k], 32'h10 + k);
        chk("word_data", got_d[k], model_word(t.vals, k));
      end
    end
    if (t.has_exp != 0 && got_d.size() == NW) begin
      chk("word0_ref", got_d[0], t.exp_w0);
      chk("wordlast_ref", got_d[NW-1], t.exp_wlast);
    end
    for (int h = 0; h < t.hold; h++) begin
      chk("hold_done", done, 1);
      chk("hold_nowrite", avm.avm_write, 0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    avm.avm_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_state", dbg_state, 0);
    chk("idle_done", done, 0);
    chk("idle_write", avm.avm_write, 0);
  endtask

  initial begin
    vec_t            tbl [4];
    vec_t            rv;
    logic [N*RW-1:0] basic;
    for (int i = 0; i < N; i++) basic[i*RW +: RW] = RW'(32'h100 * (i + 1));
    tbl[0] = '{basic, 0, 0, 0, 0, 20, 6 + NW - 4, 1, 64'h00000200_00000100, BASIC_LAST};
    tbl[1] = '{basic, 0, 0, 1, 3, 0, 9 + NW - 4, 1, 64'h00000200_00000100, BASIC_LAST};
    tbl[2] = '{basic, 0, 1, 0, 0, 2, 6 + NW - 4, 1, 64'h00000200_00000100, BASIC_LAST};
    tbl[3] = '{'1, 0, 0, 0, 0, 1, 6 + NW - 4, 1, 64'h00FFFFFF_00FFFFFF, ONES_LAST};

    for (int i = 0; i < N; i++) c_in[i] = '0;
    avm.avm_waitrequest = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_address", avm.avm_address, 0);
    chk("rst_write", avm.avm_write, 0);
    chk("rst_writedata", avm.avm_writedata, 0);
    chk("rst_byteenable", avm.avm_byteenable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbg_state", dbg_state, 0);
    chk("rst_dbg_word", dbg_word, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) run_burst(tbl[v]);

    // reset while word 2 is on the bus, then a full rewrite from the base address
    for (int i = 0; i < N; i++) c_in[i] = basic[i*RW +: RW];
    start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (avm.avm_write && avm.avm_address == 32'h12) break;
    end
    chk("midburst_addr", avm.avm_address, 32'h12);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_write", avm.avm_write, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_state", dbg_state, 0);
    chk("midrst_address", avm.avm_address, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_burst(tbl[0]);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) rv.vals[i*RW +: RW] = RW'($urandom);
      rv.pct        = $urandom_range(60);
      rv.mutate     = $urandom_range(1);
      rv.stall_word = 0;
      rv.stall_len  = 0;
      rv.hold       = $urandom_range(4);
      rv.exp_done   = -1;
      rv.has_exp    = 0;
      rv.exp_w0     = '0;
      rv.exp_wlast  = '0;
      run_burst(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/result_writeback.md
# result_writeback

Avalon-MM write master that sits directly downstream of the MAC8 result lanes. When the top-level FSM reaches its done state, this block snapshots all N 24-bit accumulator outputs, packs them two per 64-bit word, and writes them to the memory wrapper at a fixed base address. It runs alongside the read-side controller, which fills the FIFOs, and it reports completion so the top can flag results as committed.

## Interface
- N, 8, number of result lanes; must be even and at least 2.
- RES_WIDTH, 24, width of each lane result; must be 32 or less.
- BASE_ADDR, 32'h0000_0010, word address of the first result word.

Ports, listed as name, direction, width, and meaning:
- clk, in, 1, single clock; all logic is rising-edge.
- rst_n, in, 1, reset that is synchronous and active-low.
- start, in, 1, level request; sampled only in IDLE.
- c_in[0:N-1], in, RES_WIDTH each, lane results (unpacked array).
- avm_address, out, 32, word address.
- avm_write, out, 1, write request.
- avm_writedata, out, 64, packed result word.
- avm_byteenable, out, 8, always 8'hFF while avm_write is high, otherwise 8'h00.
- avm_waitrequest, in, 1, slave stall.
- busy, out, 1, high in CAPTURE and WRITE.
- done, out, 1, high in DONE.
- dbg_state, out, 2, encoding is IDLE=0, CAPTURE=1, WRITE=2, DONE=3.
- dbg_word, out, 3, index of the word currently being written.

## Operation
- Word count:
  - W = N/2.
  - W = N/2 + 1 when RESULT_WB_CHECKSUM_EN is defined.
- Word k packing, for k < N/2:
  - avm_writedata[31:0] = zero-extend(snap[2k]).
  - avm_writedata[63:32] = zero-extend(snap[2k+1]).
- Address of word k is BASE_ADDR + k, with 32-bit wrap.
- IDLE state:
  - All outputs are 0.
  - If start=1, capture c_in into snap[] and go to CAPTURE.
- CAPTURE state:
  - Lasts one cycle.
  - Clears the word index to 0 and loads the first word into the output registers.
  - Next state is WRITE.
- WRITE state:
  - avm_write=1; address, data and byteenable are held stable while avm_waitrequest=1.
  - A transfer is accepted on a cycle where avm_write=1 and avm_waitrequest=0.
  - On acceptance of a word that is not the last, increment the index and present the next word on the following cycle. avm_write stays high and there are no bubbles.
  - On acceptance of the last word, go to DONE and drive avm_write to 0 on the next cycle.
- DONE state:
  - done=1.
  - Stays in DONE while start=1.
  - Returns to IDLE on the first cycle that start=0. This allows the level-held start used by the top FSM.
- The snapshot is frozen from the capture edge until the return to IDLE. Changes on c_in during that time are ignored.
- A start deassertion during CAPTURE or WRITE is ignored; the sequence always completes.
- avm_waitrequest is don't-care whenever avm_write=0.

## Timing
- Reset: on a clock edge with rst_n=0, the state becomes IDLE and all outputs are 0 on the following cycle.
  - avm_address=0, avm_write=0, avm_writedata=0, avm_byteenable=0, busy=0, done=0, dbg_state=0, dbg_word=0.
  - A reset during WRITE drops avm_write immediately. The partial transfer is abandoned, which is permitted only at reset.
- Cycle numbering: start is first seen high in IDLE at edge 0.
  - Cycle 1 is CAPTURE.
  - avm_write is first high in cycle 2.
- With zero wait states, the W words are accepted in cycles 2 through W+1, and done=1 from cycle W+2.
- Each wait-state cycle delays every later event by exactly one cycle.
- Outputs are driven only from registers; there is no combinational path from avm_waitrequest to avm_write or avm_address.

## Configuration
- RESULT_WB_CHECKSUM_EN, when defined:
  - Appends a trailer word at address BASE_ADDR + N/2.
  - Trailer [31:0] is the sum of all N snap values, zero-extended, modulo 2^32.
  - Trailer [63:32] is 32'hA5A5_A5A5.
  - W becomes N/2 + 1.
- When undefined: no trailer is written, and there is no adder logic.

## Test plan
- Basic writeback: reset, then set c_in[i] = 24'h000100·(i+1) for N=8, with waitrequest=0 and start held high. Require exactly 4 writes:
  - address 0x10, data 64'h00000200_00000100.
  - address 0x11, data 64'h00000400_00000300.
  - address 0x12, data 64'h00000600_00000500.
  - address 0x13, data 64'h00000800_00000700.
  - done=1 in cycle 6.
- Wait states: same stimulus, with waitrequest=1 for 3 cycles on word 1. Require that word 1's address and data hold constant for 4 cycles, that there are no duplicate writes, and that done=1 in cycle 9.
- Snapshot isolation: change all c_in to 24'hFFFFFF one cycle after capture. All written data must equal the original values.
- Start handshake: hold start high for 20 cycles after done, then drop it. Require no second write burst, return to IDLE one cycle after start falls, and a fresh burst on the next start.
- Reset mid-burst: assert rst_n=0 during word 2. Require avm_write=0, busy=0 and dbg_state=0 the next cycle, and that a new start rewrites from 0x10.
- With RESULT_WB_CHECKSUM_EN, using the basic stimulus: require a fifth write at address 0x14 with data 64'hA5A5A5A5_00002400, followed by done.
